// File: rtl/reg_arbiter.sv
// Two-requester round-robin arbiter guarding a shared WIDTH-bit register.
// Each write takes three edges: grant, load/ack, return to idle.
module reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             res,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] Q,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             sel_r;   // requester currently being served
  logic             sel_s;
  logic             last_r;  // requester served most recently
  logic             last_s;
  logic [WIDTH-1:0] q_s;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             ack0_s;
  logic             ack1_s;
  logic             busy_s;
  logic             granted_req_s;

  // Next-state, next-data and next-output decode
  always_comb begin
    state_s       = state_r;
    sel_s         = sel_r;
    last_s        = last_r;
    q_s           = Q;
    granted_req_s = 1'b0;

    case (state_r)
      IDLE: begin
        // On a tie the requester not served last wins
        if (req0 && req1) begin
          state_s = GRANT;
          sel_s   = ~last_r;
        end else if (req0) begin
          state_s = GRANT;
          sel_s   = 1'b0;
        end else if (req1) begin
          state_s = GRANT;
          sel_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        granted_req_s = sel_r ? req1 : req0;
        if (granted_req_s) begin
          q_s     = sel_r ? d1 : d0;
          state_s = ACK;
        end else begin
          // Requester withdrew: drop the write and leave the pointer alone
          state_s = IDLE;
        end
      end
      ACK: begin
        last_s  = sel_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    gnt0_s = (state_s == GRANT) && (sel_s == 1'b0);
    gnt1_s = (state_s == GRANT) && (sel_s == 1'b1);
    ack0_s = (state_s == ACK)   && (sel_s == 1'b0);
    ack1_s = (state_s == ACK)   && (sel_s == 1'b1);
    busy_s = (state_s != IDLE);
  end

  // State, pointer, shared register and registered outputs
  always_ff @(posedge CLK or posedge res) begin
    if (res) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      last_r  <= 1'b1;
      Q       <= {WIDTH{1'b0}};
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      last_r  <= last_s;
      Q       <= q_s;
      gnt0    <= gnt0_s;
      gnt1    <= gnt1_s;
      ack0    <= ack0_s;
      ack1    <= ack1_s;
      busy    <= busy_s;
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: a per-cycle vector table plus hand-written
// sequences for asynchronous reset and input-without-edge behaviour.
module tb_reg_arbiter;

  logic       CLK;
  logic       res;
  logic       req0;
  logic       req1;
  logic [7:0] d0;
  logic [7:0] d1;
  logic       gnt0;
  logic       gnt1;
  logic       ack0;
  logic       ack1;
  logic [7:0] Q;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // ctl bit order: gnt0 gnt1 ack0 ack1 busy
  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] ctl;
    logic [7:0] q;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  reg_arbiter #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .res  (res),
    .req0 (req0),
    .req1 (req1),
    .d0   (d0),
    .d1   (d1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .ack0 (ack0),
    .ack1 (ack1),
    .Q    (Q),
    .busy (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #500 CLK = ~CLK;
  end

  task automatic check(input string nm, input logic [4:0] ec, input logic [7:0] eq);
    logic [4:0] ac;
    ac = {gnt0, gnt1, ack0, ack1, busy};
    checks++;
    if (ac !== ec || Q !== eq) begin
      failures++;
      $display("FAIL %s: got g0g1a0a1busy=%b Q=%h, expected g0g1a0a1busy=%b Q=%h",
               nm, ac, Q, ec, eq);
    end
  endtask

  initial begin
    // Tie after reset, requester 0 held through its ack
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 8'h22, 5'b10001, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'h11, 8'h22, 5'b00101, 8'h11};
    vecs[2]  = '{1'b1, 1'b1, 8'h11, 8'h22, 5'b00000, 8'h11};
    vecs[3]  = '{1'b1, 1'b1, 8'h11, 8'h22, 5'b01001, 8'h11};
    vecs[4]  = '{1'b1, 1'b1, 8'h11, 8'h22, 5'b00011, 8'h22};
    vecs[5]  = '{1'b0, 1'b0, 8'h11, 8'h22, 5'b00000, 8'h22};
    // Single write from requester 0
    vecs[6]  = '{1'b1, 1'b0, 8'h3C, 8'h22, 5'b10001, 8'h22};
    vecs[7]  = '{1'b1, 1'b0, 8'h3C, 8'h22, 5'b00101, 8'h3C};
    vecs[8]  = '{1'b0, 1'b0, 8'h3C, 8'h22, 5'b00000, 8'h3C};
    // Round-robin: req0 held, req1 pulsed per write
    vecs[9]  = '{1'b1, 1'b0, 8'hA1, 8'hB2, 5'b10001, 8'h3C};
    vecs[10] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 5'b00101, 8'hA1};
    vecs[11] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 5'b00000, 8'hA1};
    vecs[12] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 5'b01001, 8'hA1};
    vecs[13] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 5'b00011, 8'hB2};
    vecs[14] = '{1'b1, 1'b0, 8'hC3, 8'hB2, 5'b00000, 8'hB2};
    vecs[15] = '{1'b1, 1'b0, 8'hC3, 8'hB2, 5'b10001, 8'hB2};
    vecs[16] = '{1'b1, 1'b1, 8'hC3, 8'hD4, 5'b00101, 8'hC3};
    vecs[17] = '{1'b1, 1'b1, 8'hC3, 8'hD4, 5'b00000, 8'hC3};
    vecs[18] = '{1'b1, 1'b1, 8'hC3, 8'hD4, 5'b01001, 8'hC3};
    vecs[19] = '{1'b1, 1'b1, 8'hC3, 8'hD4, 5'b00011, 8'hD4};
    vecs[20] = '{1'b0, 1'b0, 8'hC3, 8'hD4, 5'b00000, 8'hD4};
    // Abandon: Q=55 from requester 0, then requester 1 withdraws in GRANT
    vecs[21] = '{1'b1, 1'b0, 8'h55, 8'hD4, 5'b10001, 8'hD4};
    vecs[22] = '{1'b1, 1'b0, 8'h55, 8'hD4, 5'b00101, 8'h55};
    vecs[23] = '{1'b0, 1'b0, 8'h55, 8'hD4, 5'b00000, 8'h55};
    vecs[24] = '{1'b0, 1'b1, 8'h55, 8'hEE, 5'b01001, 8'h55};
    vecs[25] = '{1'b0, 1'b0, 8'h55, 8'hEE, 5'b00000, 8'h55};
    vecs[26] = '{1'b1, 1'b1, 8'h66, 8'h77, 5'b01001, 8'h55};
    vecs[27] = '{1'b1, 1'b1, 8'h66, 8'h77, 5'b00011, 8'h77};
    vecs[28] = '{1'b0, 1'b0, 8'h66, 8'h77, 5'b00000, 8'h77};

    res  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    d0   = 8'h00;
    d1   = 8'h00;
    repeat (2) @(posedge CLK);
    #1 check("reset_state", 5'b00000, 8'h00);
    @(negedge CLK);
    res = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      req0 = vecs[i].r0;
      req1 = vecs[i].r1;
      d0   = vecs[i].a;
      d1   = vecs[i].b;
      @(posedge CLK);
      #1 check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].q);
    end

    // Load A5 from requester 0 so the pointer favours requester 1 on a tie
    @(negedge CLK);
    req0 = 1'b1;
    d0   = 8'hA5;
    @(posedge CLK);
    #1 check("a5_grant", 5'b10001, 8'h77);
    @(posedge CLK);
    #1 check("a5_ack", 5'b00101, 8'hA5);
    @(negedge CLK);
    req0 = 1'b0;
    @(posedge CLK);
    #1 check("a5_idle", 5'b00000, 8'hA5);

    // Inputs alone must not move any output
    #200;
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 8'h00;
    d1   = 8'h00;
    #1 check("no_edge_hold", 5'b00000, 8'hA5);

    // Short mid-cycle reset pulse clears everything before the next edge
    #50;
    res = 1'b1;
    #10 check("async_reset_pulse", 5'b00000, 8'h00);
    #5;
    res = 1'b0;
    @(posedge CLK);
    #1 check("tie_after_pulse", 5'b10001, 8'h00);
    @(negedge CLK);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge CLK);
    #1 check("abandon_after_pulse", 5'b00000, 8'h00);

    // Reset during GRANT aborts the write, then a normal write follows
    @(negedge CLK);
    req0 = 1'b1;
    d0   = 8'hFF;
    @(posedge CLK);
    #1 check("ff_grant", 5'b10001, 8'h00);
    #300;
    res = 1'b1;
    #10 check("ff_reset_in_grant", 5'b00000, 8'h00);
    @(posedge CLK);
    #1 check("ff_no_ack", 5'b00000, 8'h00);
    @(negedge CLK);
    res = 1'b0;
    @(posedge CLK);
    #1 check("ff_regrant", 5'b10001, 8'h00);
    @(posedge CLK);
    #1 check("ff_ack", 5'b00101, 8'hFF);
    @(negedge CLK);
    req0 = 1'b0;
    @(posedge CLK);
    #1 check("ff_idle", 5'b00000, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the shared register and of each write-data port.
REQ-002 CLK  input  1  single clock; all state changes on rising edge except reset.
REQ-003 res  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  write request from requester 0; level, held until ack0 or abandoned.
REQ-005 req1  input  1  write request from requester 1; same rules as req0.
REQ-006 d0  input  WIDTH  write data from requester 0; stable while gnt0 high.
REQ-007 d1  input  WIDTH  write data from requester 1; stable while gnt1 high.
REQ-008 gnt0  output  1  registered grant to requester 0.
REQ-009 gnt1  output  1  registered grant to requester 1.
REQ-010 ack0  output  1  registered one-cycle write-complete pulse to requester 0.
REQ-011 ack1  output  1  registered one-cycle write-complete pulse to requester 1.
REQ-012 Q  output  WIDTH  shared register contents, direct flop output.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT, ACK.
REQ-015 IDLE, no req high: SHALL stay in IDLE; Q holds.
REQ-016 IDLE, one req high: SHALL enter GRANT with the matching gnt high on the next edge.
REQ-017 IDLE, both req high: SHALL grant the requester not served last, per a 1-bit last-served pointer.
REQ-018 gnt0 and gnt1 SHALL never be high together; each is high only in GRANT.
REQ-019 GRANT, granted req still high: at the next edge Q SHALL load the granted requester's data; the state SHALL become ACK.
REQ-020 GRANT, granted req low: the write SHALL be abandoned, with Q unchanged, no ack, pointer unchanged, next state IDLE.
REQ-021 ACK: the granted requester's ack SHALL be high for exactly one cycle; the pointer SHALL update to that requester; the next state SHALL be IDLE.
REQ-022 Latency: req sampled at edge N gives gnt after N, Q updated at N+1, ack high from N+1 to N+2, IDLE after N+2.
REQ-023 New requests SHALL be ignored outside IDLE; a request pending at ACK exit SHALL be arbitrated in IDLE on the following edge.
REQ-024 A requester holding req through its own ACK SHALL be treated as a new request in IDLE; if the other req is high, the other requester SHALL win.
REQ-025 Input changes SHALL never change outputs without a clock edge, except through res.

Reset
REQ-026 res high SHALL immediately, without a clock edge, force: state IDLE; Q all zeros; gnt0, gnt1, ack0, ack1 and busy low; pointer set so that req0 wins the first tie.
REQ-027 res asserted in GRANT or ACK SHALL abort the operation: Q = 0 and no ack.
REQ-028 Operation SHALL resume on the first rising edge after res falls; req values are sampled then.

Verification
REQ-029 Reset: res pulse of 15ps mid-cycle with Q=8'hA5 -> Q=8'h00 and all outputs low within 10ps, before the next edge.
REQ-030 Single write: req0=1, d0=8'h3C in IDLE -> gnt0 for 1 cycle, Q=8'h3C at the following edge, ack0 for 1 cycle, busy low after 3 edges.
REQ-031 Tie after reset: req0=req1=1, d0=8'h11, d1=8'h22 held -> sequence Q=8'h11/ack0, then Q=8'h22/ack1; gnt never both high.
REQ-032 Round-robin: req0 held high, req1 pulsed per write -> grants alternate 0,1,0,1; ack0 and ack1 never in the same cycle.
REQ-033 Abandon: req1 raised, then dropped during GRANT with Q=8'h55 -> Q stays 8'h55, no ack1, IDLE next edge; the next tie grants requester 1.
REQ-034 Reset mid-write: res asserted during GRANT with d0=8'hFF -> Q=8'h00, no ack0; after release with req0=1, the normal 3-cycle write completes.
